// File: rtl/ext_bus_initiator.sv
// ext_bus_initiator: issues word-access commands (single or burst) onto the
// FPGA-side external bus. It holds each beat until the bridge acknowledges or
// the wait times out. Each beat result goes back on a ready/valid response port.
module ext_bus_initiator #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  input  logic [DATA_W-1:0]   cmd_wdata,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                rsp_last,
  // external bus
  output logic [ADDR_W-1:0]   bus_address,
  output logic [DATA_W/8-1:0] bus_byte_enable,
  output logic                bus_read,
  output logic                bus_write,
  output logic [DATA_W-1:0]   bus_write_data,
  input  logic                bus_acknowledge,
  input  logic [DATA_W-1:0]   bus_read_data
);

  localparam int unsigned BE_W     = DATA_W / 8;
  // The counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t           state;
  logic             wr_q;
  logic [7:0]       beats_left;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit_c;

  // Timeout fires on the last allowed wait cycle; TIMEOUT == 0 disables it.
  assign tmo_hit_c = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TMO_LAST));

  // Command / beat / response sequencer with all bus and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      cmd_ready       <= 1'b1;
      wr_q            <= 1'b0;
      beats_left      <= 8'd0;
      tmo_cnt         <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_error       <= 1'b0;
      rsp_last        <= 1'b0;
      bus_address     <= '0;
      bus_byte_enable <= '0;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      bus_write_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready       <= 1'b0;
            wr_q            <= cmd_write;
            beats_left      <= cmd_len;
            tmo_cnt         <= '0;
            bus_address     <= cmd_addr & ~ADDR_W'(3);
            bus_byte_enable <= BE_W'(cmd_byteenable);
            bus_write_data  <= cmd_wdata;
            bus_read        <= ~cmd_write;
            bus_write       <= cmd_write;
            state           <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          // Ack has priority over a coincident timeout.
          if (bus_acknowledge) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= wr_q ? '0 : bus_read_data;
            rsp_last  <= (beats_left == 8'd0);
            state     <= ST_RESP;
          end else if (tmo_hit_c) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
            rsp_last  <= 1'b1;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              beats_left  <= beats_left - 8'd1;
              bus_address <= bus_address + ADDR_W'(4);
              tmo_cnt     <= '0;
              bus_read    <= ~wr_q;
              bus_write   <= wr_q;
              state       <= ST_ACCESS;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          bus_read  <= 1'b0;
          bus_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
